led_output_scheduler: RTL and testbench

Sequencer for the CPU's 8-bit LED output port. It accepts `LED`/`LEDI` writes from the execute stage and queues them in a small FIFO. Each value is shown on the LEDs for at least a programmable number of cycles, so bursts of writes stay visible. It stalls the CPU when the queue is full. It sits between the decoded operation/operand buses and the board LED pins, and replaces direct register-on-opcode output.

---
 rtl/led_output_scheduler.sv | 116 +++++++++++
 tb/tb_led_output_scheduler.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led_output_scheduler.sv
// LED output sequencer: queues LED/LEDI writes and keeps each value on the
// pins for at least HOLD_CYCLES cycles, stalling the CPU when the queue fills.
module led_output_scheduler #(
   parameter int         HOLD_CYCLES = 4,
   parameter int         DEPTH       = 4,
   parameter int         CNT_W       = 16,
   parameter logic [5:0] LED_OP      = 6'h0C,
   parameter logic [5:0] LEDI_OP     = 6'h0D
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [5:0]               operation,
   input  logic [31:0]              in,
   input  logic                     flush,
   output logic [7:0]               out,
   output logic                     stall,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [7:0]              out_q, out_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic [DEPTH-1:0][7:0]   mem_q, mem_d;

   logic is_write, accept, fifo_empty, slot_free, bypass, push, pop;

   always_comb begin
      is_write   = (operation == LED_OP) || (operation == LEDI_OP);
      fifo_empty = (level_q == '0);
      stall      = (level_q == LW'(DEPTH));
      accept     = is_write && !stall && !flush;
      // A hold with cnt==0 is in its last cycle, so a new value may replace it
      slot_free  = fifo_empty && ((state_q == IDLE) || (cnt_q == '0));
      bypass     = accept && slot_free;
      push       = accept && !slot_free;
      pop        = !flush && !fifo_empty && ((state_q == IDLE) || (cnt_q == '0));
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      out_d    = out_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      mem_d    = mem_q;

      if (flush) begin
         state_d  = IDLE;
         cnt_d    = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (bypass) begin
            out_d   = in[7:0];
            cnt_d   = HOLD_RELOAD;
            state_d = HOLD;
         end else if (pop) begin
            out_d    = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d    = HOLD_RELOAD;
            state_d  = HOLD;
         end else if (state_q == HOLD) begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = IDLE;
         end

         if (push) begin
            mem_d[wr_ptr_q] = in[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end

         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         out_q    <= 8'h00;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         mem_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         out_q    <= out_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         mem_q    <= mem_d;
      end
   end

   assign out   = out_q;
   assign level = level_q;
   assign busy  = (state_q == HOLD) || (level_q != '0);

endmodule

// File: tb/tb_led_output_scheduler.sv
// Directed bench for led_output_scheduler (HOLD_CYCLES=4, DEPTH=4).
module tb_led_output_scheduler;

   localparam logic [5:0] LED  = 6'h0C;
   localparam logic [5:0] LEDI = 6'h0D;
   localparam logic [5:0] NOP  = 6'h00;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  operation;
   logic [31:0] in;
   logic        flush;
   logic [7:0]  out;
   logic        stall;
   logic        busy;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;

   led_output_scheduler #(.HOLD_CYCLES(4), .DEPTH(4), .CNT_W(16),
                          .LED_OP(LED), .LEDI_OP(LEDI)) dut (
      .clk(clk), .reset(reset), .operation(operation), .in(in),
      .flush(flush), .out(out), .stall(stall), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [31:0] val);
      operation = op;
      in        = val;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0;
      drive(LED, 32'hFF);
      step(); step();
      check("rst_out", out, 8'h00);
      check("rst_stall", stall, 0);
      check("rst_busy", busy, 0);
      check("rst_level", level, 0);
      reset = 1'b0;
      drive(NOP, 0);
      step();
      check("idle_out", out, 8'h00);

      // single write, 4-cycle hold
      drive(LEDI, 32'h1A5);
      step();
      drive(NOP, 0);
      check("single_out", out, 8'hA5);
      check("single_busy0", busy, 1);
      for (int i = 1; i < 4; i++) begin
         step();
         check("single_busy_hold", busy, 1);
      end
      step();
      check("single_busy_end", busy, 0);
      check("single_out_keep", out, 8'hA5);

      // other opcode is ignored
      drive(6'h15, 32'h77);
      step(); step();
      check("nonled_out", out, 8'hA5);
      check("nonled_level", level, 0);
      check("nonled_busy", busy, 0);
      drive(NOP, 0);
      step();

      // boundary: write lands on the cnt==0 cycle
      drive(LED, 32'h11);
      step();
      drive(NOP, 0);
      step(); step(); step();
      check("bnd_prev_out", out, 8'h11);
      drive(LED, 32'h3C);
      step();
      drive(NOP, 0);
      check("bnd_out", out, 8'h3C);
      check("bnd_level", level, 0);
      check("bnd_busy", busy, 1);
      step(); step(); step();
      check("bnd_hold_out", out, 8'h3C);
      check("bnd_hold_busy", busy, 1);
      step();
      check("bnd_end_busy", busy, 0);

      // burst: 01 bypasses, queue fills, 07 waits for stall to drop
      drive(LED, 32'h01); step();
      check("burst_e0_out", out, 8'h01);
      check("burst_e0_level", level, 0);
      drive(LED, 32'h02); step(); check("burst_e1_level", level, 1);
      drive(LED, 32'h03); step(); check("burst_e2_level", level, 2);
      drive(LED, 32'h04); step(); check("burst_e3_level", level, 3);
      drive(LED, 32'h05); step();
      check("burst_e4_out", out, 8'h02);
      check("burst_e4_level", level, 3);
      drive(LED, 32'h06); step();
      check("burst_e5_level", level, 4);
      check("burst_e5_stall", stall, 1);
      drive(LED, 32'h07); step();
      check("burst_e6_level", level, 4);
      step();
      check("burst_e7_level", level, 4);
      check("burst_e7_out", out, 8'h02);
      step();
      check("burst_e8_out", out, 8'h03);
      check("burst_e8_level", level, 3);
      check("burst_e8_stall", stall, 0);
      step();
      drive(NOP, 0);
      check("burst_e9_level", level, 4);
      check("burst_e9_stall", stall, 1);
      for (int e = 10; e <= 29; e++) begin
         step();
         check("burst_out", out, (e >= 28) ? 8'h07 : 8'((e / 4) + 1));
         check("burst_busy", busy, (e < 28) ? 1 : 0);
         check("burst_level", level,
               (e < 12) ? 4 : (e < 16) ? 3 : (e < 20) ? 2 : (e < 24) ? 1 : 0);
      end

      // flush with three queued and a simultaneous write
      drive(LED, 32'h21); step();
      drive(LED, 32'h22); step();
      drive(LED, 32'h23); step();
      drive(LED, 32'h24); step();
      check("flush_pre_level", level, 3);
      drive(LED, 32'h99);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(NOP, 0);
      check("flush_level", level, 0);
      check("flush_busy", busy, 0);
      check("flush_out", out, 8'h21);
      for (int i = 0; i < 6; i++) begin
         step();
         check("flush_out_after", out, 8'h21);
      end

      // reset while holding with a non-empty queue
      drive(LED, 32'h41); step();
      drive(LED, 32'h42); step();
      drive(LED, 32'h43); step();
      check("rst2_pre_level", level, 2);
      drive(NOP, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst2_out", out, 8'h00);
      check("rst2_level", level, 0);
      check("rst2_busy", busy, 0);
      check("rst2_stall", stall, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
